// File: rtl/angle_pipe_arbiter_if.sv
// Requester-side bus of angle_pipe_arbiter: the (x, y) request handshake and the
// one-hot result delivery shared by all requesters.
interface angle_pipe_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16
);
  logic [N_REQ-1:0]        req_vld_i;
  logic [N_REQ*DATA_W-1:0] req_x_i;
  logic [N_REQ*DATA_W-1:0] req_y_i;
  logic [N_REQ-1:0]        req_rdy_o;
  logic [N_REQ-1:0]        res_vld_o;
  logic [DATA_W-1:0]       res_angle_o;

  modport master (
    output req_vld_i, req_x_i, req_y_i,
    input  req_rdy_o, res_vld_o, res_angle_o
  );

  modport slave (
    input  req_vld_i, req_x_i, req_y_i,
    output req_rdy_o, res_vld_o, res_angle_o
  );
endinterface

// File: rtl/angle_pipe_arbiter.sv
// Round-robin front end sharing one angle pipeline among N_REQ requesters; requester IDs ride
// a tag delay line matched to the pipeline. Optional macro: ANGLE_PIPE_ARB_TAG_CHECK_EN.
module angle_pipe_arbiter #(
  parameter int N_REQ           = 4,
  parameter int DATA_W          = 16,
  parameter int PIPE_LATENCY    = 18,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  angle_pipe_arbiter_if.slave   req_bus,
  output logic [DATA_W-1:0]     pipe_x_o,
  output logic [DATA_W-1:0]     pipe_y_o,
  output logic                  pipe_vld_o,
  input  logic [DATA_W-1:0]     pipe_angle_i,
  input  logic                  pipe_vld_i,
  output logic                  busy_o,
  output logic                  err_o
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef logic [ID_W-1:0]   id_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [DATA_W-1:0] word_t;

  word_t            x_words [N_REQ];
  word_t            y_words [N_REQ];
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] cnt_nonzero_next;

  id_t              ptr_reg;
  id_t              grant_id;
  logic             grant_any;
  logic             handshake;
  logic [N_REQ-1:0] grant;

  logic             pipe_vld_reg;
  word_t            pipe_x_reg;
  word_t            pipe_y_reg;
  id_t              issue_id_reg;

  logic             tail_vld;
  id_t              tail_id;
  logic [N_REQ-1:0] tail_onehot;

  logic [N_REQ-1:0] res_vld_reg;
  word_t            res_angle_reg;
  logic             busy_reg;

  // Per-requester word unpacking, credit counters and result decode.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    cnt_t cnt_reg;
    cnt_t cnt_next;
    logic inc;
    logic dec;

    assign x_words[gi] = req_bus.req_x_i[gi*DATA_W +: DATA_W];
    assign y_words[gi] = req_bus.req_y_i[gi*DATA_W +: DATA_W];

    assign eligible[gi]    = req_bus.req_vld_i[gi] && (cnt_reg < MAX_CNT);
    assign tail_onehot[gi] = tail_vld && (tail_id == id_t'(gi));

    assign inc = handshake && (grant_id == id_t'(gi));
    assign dec = res_vld_reg[gi] && (cnt_reg != '0);

    assign cnt_next = (inc && !dec) ? cnt_reg + 1'b1 :
                      (dec && !inc) ? cnt_reg - 1'b1 : cnt_reg;

    assign cnt_nonzero_next[gi] = (cnt_next != '0);

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_next;
      end
    end
  end

  // Scan ptr+1, ptr+2, ... so the most recent winner has the lowest priority.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = ptr_reg;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr_reg) + k) % N_REQ;
      if (!grant_any && eligible[id_t'(idx)]) begin
        grant_any = 1'b1;
        grant_id  = id_t'(idx);
      end
    end
  end

  assign handshake = grant_any && !rst;

  always_comb begin
    grant = '0;
    if (handshake) begin
      grant[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg      <= id_t'(N_REQ - 1);
      pipe_vld_reg <= 1'b0;
      pipe_x_reg   <= '0;
      pipe_y_reg   <= '0;
      issue_id_reg <= '0;
    end else begin
      pipe_vld_reg <= handshake;
      if (handshake) begin
        ptr_reg      <= grant_id;
        issue_id_reg <= grant_id;
        pipe_x_reg   <= x_words[grant_id];
        pipe_y_reg   <= y_words[grant_id];
      end
    end
  end

  // Stage 0 is loaded from the issue register, so the tail lines up with pipe_vld_i.
  for (genvar gi = 0; gi < PIPE_LATENCY; gi++) begin : g_tag
    logic vld_reg;
    id_t  id_reg;
    logic vld_in;
    id_t  id_in;

    if (gi == 0) begin : g_head
      assign vld_in = pipe_vld_reg;
      assign id_in  = issue_id_reg;
    end else begin : g_body
      assign vld_in = g_tag[gi-1].vld_reg;
      assign id_in  = g_tag[gi-1].id_reg;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_reg <= 1'b0;
        id_reg  <= '0;
      end else begin
        vld_reg <= vld_in;
        id_reg  <= id_in;
      end
    end
  end

  assign tail_vld = g_tag[PIPE_LATENCY-1].vld_reg;
  assign tail_id  = g_tag[PIPE_LATENCY-1].id_reg;

  // Results are steered by the tag alone; a pipe_vld_i pulse under an empty tag is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld_reg   <= '0;
      res_angle_reg <= '0;
      busy_reg      <= 1'b0;
    end else begin
      res_vld_reg <= tail_onehot;
      if (tail_vld) begin
        res_angle_reg <= pipe_angle_i;
      end
      busy_reg <= |cnt_nonzero_next;
    end
  end

`ifdef ANGLE_PIPE_ARB_TAG_CHECK_EN
  logic err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (tail_vld && !pipe_vld_i) begin
      err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
`else
  logic unused_pipe_vld;

  assign unused_pipe_vld = pipe_vld_i;
  assign err_o           = 1'b0;
`endif

  assign req_bus.req_rdy_o   = grant;
  assign req_bus.res_vld_o   = res_vld_reg;
  assign req_bus.res_angle_o = res_angle_reg;
  assign pipe_vld_o          = pipe_vld_reg;
  assign pipe_x_o            = pipe_x_reg;
  assign pipe_y_o            = pipe_y_reg;
  assign busy_o              = busy_reg;
endmodule

// File: tb/tb_angle_pipe_arbiter.sv
// Directed bench for angle_pipe_arbiter with a delay-line pipeline model and a result scoreboard.
module tb_angle_pipe_arbiter;
  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int L    = 18;
  localparam int MAXO = 2;
`ifdef ANGLE_PIPE_ARB_TAG_CHECK_EN
  localparam logic TAG_CHK = 1'b1;
`else
  localparam logic TAG_CHK = 1'b0;
`endif

  typedef struct {
    int          id;
    logic [DW-1:0] angle;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  angle_pipe_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  logic [DW-1:0] pipe_x;
  logic [DW-1:0] pipe_y;
  logic          pipe_vld_out;
  logic [DW-1:0] pipe_angle;
  logic          pipe_vld_in;
  logic          busy;
  logic          err;

  angle_pipe_arbiter #(
    .N_REQ(N), .DATA_W(DW), .PIPE_LATENCY(L), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_bus      (bus),
    .pipe_x_o     (pipe_x),
    .pipe_y_o     (pipe_y),
    .pipe_vld_o   (pipe_vld_out),
    .pipe_angle_i (pipe_angle),
    .pipe_vld_i   (pipe_vld_in),
    .busy_o       (busy),
    .err_o        (err)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   model_lat = L;
  bit   skip_angle = 1'b0;
  exp_t sb[$];

  function automatic logic [DW-1:0] model_angle(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return (x * 16'd3) + (y ^ 16'h5a5a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pipeline model: a fixed delay line whose tap is chosen by model_lat.
  logic          line_vld [32] = '{default: 1'b0};
  logic [DW-1:0] line_ang [32] = '{default: '0};
  always @(posedge clk) begin
    line_vld[0] <= pipe_vld_out;
    line_ang[0] <= model_angle(pipe_x, pipe_y);
    for (int k = 1; k < 32; k++) begin
      line_vld[k] <= line_vld[k-1];
      line_ang[k] <= line_ang[k-1];
    end
  end
  assign pipe_vld_in = line_vld[model_lat-1];
  assign pipe_angle  = line_ang[model_lat-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on handshake, pop and compare on each delivered result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_vld_i[i] && bus.req_rdy_o[i]) begin
          e.id    = i;
          e.angle = model_angle(bus.req_x_i[i*DW +: DW], bus.req_y_i[i*DW +: DW]);
          e.due   = cyc + L + 2;
          sb.push_back(e);
          $display("req %0d issued cycle %0d", i, cyc);
        end
      end
    end
    if (bus.res_vld_o !== '0) begin
      if (sb.size() == 0) begin
        chk("stray_result", 32'(bus.res_vld_o), 32'd0);
      end else begin
        e = sb.pop_front();
        $display("res %b angle=%0h cycle %0d", bus.res_vld_o, bus.res_angle_o, cyc);
        chk("res_id", 32'(bus.res_vld_o), 32'(1 << e.id));
        if (!skip_angle) chk("res_angle", 32'(bus.res_angle_o), 32'(e.angle));
        chk("res_cycle", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y);
    bus.req_x_i[i*DW +: DW] = x;
    bus.req_y_i[i*DW +: DW] = y;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (bus.res_vld_o === '0 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 40), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 80) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    bus.req_vld_i = '0;
    bus.req_x_i   = '0;
    bus.req_y_i   = '0;
    repeat (3) tick();

    bus.req_vld_i = '1;
    #1;
    chk("rdy_in_reset", 32'(bus.req_rdy_o), 32'd0);
    bus.req_vld_i = '0;
    tick();
    rst = 1'b0;
    chk("rst_pipe_vld", 32'(pipe_vld_out), 32'd0);
    chk("rst_pipe_x", 32'(pipe_x), 32'd0);
    chk("rst_pipe_y", 32'(pipe_y), 32'd0);
    chk("rst_res_vld", 32'(bus.res_vld_o), 32'd0);
    chk("rst_res_angle", 32'(bus.res_angle_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Single request from requester 2.
    set_word(2, 16'h0100, 16'h0100);
    bus.req_vld_i = 4'b0100;
    #1;
    chk("single_rdy", 32'(bus.req_rdy_o), 32'h4);
    tick();
    bus.req_vld_i = '0;
    chk("single_pipe_vld", 32'(pipe_vld_out), 32'd1);
    chk("single_pipe_x", 32'(pipe_x), 32'h0100);
    chk("single_pipe_y", 32'(pipe_y), 32'h0100);
    chk("single_busy", 32'(busy), 32'd1);
    tick();
    chk("single_pipe_idle", 32'(pipe_vld_out), 32'd0);
    chk("single_pipe_hold", 32'(pipe_x), 32'h0100);
    wait_res("single_timeout");
    chk("single_res_vld", 32'(bus.res_vld_o), 32'h4);
    chk("single_busy_at_res", 32'(busy), 32'd1);
    tick();
    chk("single_busy_after", 32'(busy), 32'd0);
    chk("single_res_clear", 32'(bus.res_vld_o), 32'd0);

    // Three requests in flight, then a one-cycle reset.
    for (int i = 0; i < N; i++) set_word(i, 16'(16'h0011 * (i + 1)), 16'(16'h0203 * (i + 1)));
    bus.req_vld_i = 4'b1110;
    repeat (3) tick();
    bus.req_vld_i = '0;
    repeat (4) tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      if (pipe_vld_in === 1'b1) pulses++;
      chk("flush_res_vld", 32'(bus.res_vld_o), 32'd0);
      chk("flush_err", 32'(err), 32'd0);
      tick();
    end
    chk("flush_pulses_seen", pulses, 32'd3);
    chk("flush_busy", 32'(busy), 32'd0);

    // Fairness: everyone requests; rotation restarts at requester 0.
    bus.req_vld_i = '1;
    #1;
    chk("post_reset_grant", 32'(bus.req_rdy_o), 32'h1);
    for (int k = 0; k < 8; k++) begin
      chk("fair_grant", 32'(bus.req_rdy_o), 32'(1 << (k % N)));
      tick();
      chk("fair_pipe_vld", 32'(pipe_vld_out), 32'd1);
    end
    chk("fair_credit_stall", 32'(bus.req_rdy_o), 32'd0);
    bus.req_vld_i = '0;
    tick();
    chk("fair_pipe_idle", 32'(pipe_vld_out), 32'd0);
    drain("fair_drain");

    // Credit limit on requester 0, including a simultaneous grant and result.
    bus.req_vld_i = 4'b0001;
    for (int off = 0; off <= 40; off++) begin
      #1;
      chk("credit_rdy", 32'(bus.req_rdy_o[0]),
          32'((off == 0) || (off == 1) || (off == 21) || (off == 22)));
      tick();
    end
    bus.req_vld_i = '0;
    drain("credit_drain");

    // Pipeline one cycle slower than the tag line.
    model_lat  = L + 1;
    skip_angle = 1'b1;
    chk("lat_err_before", 32'(err), 32'd0);
    bus.req_vld_i = 4'b0010;
    tick();
    bus.req_vld_i = '0;
    wait_res("lat_timeout");
    chk("lat_res_vld", 32'(bus.res_vld_o), 32'h2);
    chk("lat_err_at_result", 32'(err), 32'(TAG_CHK));
    repeat (5) tick();
    chk("lat_err_sticky", 32'(err), 32'(TAG_CHK));
    drain("lat_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/angle_pipe_arbiter.md
Name: angle_pipe_arbiter

Overview:
- Round-robin arbiter that shares one calc_angle_pipeline instance among N_REQ requesters, e.g. parallel Jacobi rotation units needing pivot angles.
- Accepts (x, y) requests over valid/ready, issues at most one request per cycle into the pipeline, and tracks requester IDs in a tag shift register matched to the pipeline latency.
- Routes each returned angle to the requester that issued it.
- Limits outstanding requests per requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, JACOBI_OUTPUT_WORD_WIDTH, width of x, y and angle words.
- PIPE_LATENCY, CORDIC_N_STAGES+2, cycles from pipe_vld_o to the matching pipe_vld_i.
- MAX_OUTSTANDING, 2, maximum in-flight requests per requester (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_vld_i  in  N_REQ  per-requester request valid.
- req_x_i  in  N_REQ*DATA_W  signed x words; requester i at bits [i*DATA_W +: DATA_W].
- req_y_i  in  N_REQ*DATA_W  signed y words; same packing as req_x_i.
- req_rdy_o  out  N_REQ  one-hot grant/ready; handshake when req_vld_i[i] & req_rdy_o[i].
- pipe_x_o  out  DATA_W  x to pipeline.
- pipe_y_o  out  DATA_W  y to pipeline.
- pipe_vld_o  out  1  pipeline input valid.
- pipe_angle_i  in  DATA_W  angle from pipeline.
- pipe_vld_i  in  1  pipeline output valid.
- res_vld_o  out  N_REQ  one-hot result valid; no backpressure.
- res_angle_o  out  DATA_W  result angle, shared by all requesters.
- busy_o  out  1  any request in flight.
- err_o  out  1  sticky tag/valid mismatch (see Optional Feature).

Behaviour:
- Reset values:
  - Registered outputs are 0: pipe_vld_o, pipe_x_o, pipe_y_o, res_vld_o, res_angle_o, busy_o, err_o.
  - Round-robin pointer = N_REQ-1, so requester 0 wins first.
  - Outstanding counters and the tag shift register are cleared.
- Eligibility: requester i is eligible when req_vld_i[i]=1 and outstanding[i] < MAX_OUTSTANDING.
- Grant (combinational):
  - Grant the first eligible index scanning ptr+1, ptr+2, ... modulo N_REQ.
  - req_rdy_o has at most one bit set and is 0 during rst.
  - req_rdy_o may depend on req_vld_i.
- On handshake:
  - Pointer moves to the granted index.
  - Next cycle: pipe_vld_o=1, pipe_x_o/pipe_y_o = the granted words, and a tag {valid=1, id} enters the shift register.
  - With no handshake: pipe_vld_o=0, the data registers hold, and a tag {valid=0} enters.
- Tag shift register:
  - Depth PIPE_LATENCY, advances every cycle, aligned so the tail tag matches pipe_vld_i for the same request.
- Result stage (registered):
  - When the tail tag is valid: res_vld_o = one-hot(tail id) and res_angle_o = pipe_angle_i.
  - Otherwise res_vld_o = 0 and res_angle_o holds its value.
- Latency: handshake cycle T produces res_vld_o in cycle T+PIPE_LATENCY+2.
- Throughput: one request per cycle sustained.
- Outstanding counters:
  - Increment on handshake, decrement when the corresponding res_vld_o bit is 1.
  - Simultaneous increment and decrement leaves the counter unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- busy_o is registered: OR of (outstanding != 0).
- Stray results: pipe_vld_i=1 with an invalid tail tag (e.g. a post-reset flush) is ignored and produces no res_vld_o.
- Reset mid-operation: in-flight tags and counters are discarded, and the corresponding results are never delivered.
- Requester dropping req_vld_i without a handshake: no effect on pointer or counters.

Optional Feature:
- Macro: ANGLE_PIPE_ARB_TAG_CHECK_EN.
- Defined:
  - err_o is set when the tail tag is valid but pipe_vld_i=0 in that cycle, i.e. a latency mismatch.
  - err_o is sticky until rst.
  - The result is still delivered using the tag.
- Undefined:
  - err_o is tied to 0.
  - pipe_vld_i is unused; results are driven by tags only.

Test Plan:
- Single request: req 2 issues x=0x0100, y=0x0100; model pipeline with PIPE_LATENCY=18 -> res_vld_o=4'b0100 exactly 20 cycles after the handshake, res_angle_o = model output, busy_o deasserts the cycle after.
- Fairness: all 4 requesters hold req_vld_i=1 with MAX_OUTSTANDING=7 -> grants ordered 0,1,2,3,0,1,... with one pipe_vld_o per cycle and no gaps.
- Credit limit: MAX_OUTSTANDING=2, only req 1 active -> exactly two handshakes, then req_rdy_o[1]=0 until the first result returns, then exactly one new grant per returned result.
- Simultaneous increment/decrement: req 0 hands shakes in the same cycle its earlier result is delivered -> outstanding[0] unchanged, no overflow.
- Reset mid-flight: three requests in flight, assert rst for 1 cycle -> no res_vld_o for the flushed results even though pipe_vld_i pulses arrive, err_o=0, the next grant goes to requester 0.
- With ANGLE_PIPE_ARB_TAG_CHECK_EN: model pipeline latency set one cycle too long -> err_o rises at the first expected result and stays 1; without the macro, err_o stays 0.
